// File: rtl/mem_block_ctrl.sv
// Block-transfer master for a single-port distributed memory: fills an address
// range with a constant/incrementing pattern, or streams a range out over valid/ready.
module mem_block_ctrl #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Op,
    input  logic [AW-1:0] BaseAddr,
    input  logic [AW:0]   Length,
    input  logic [DW-1:0] FillData,
    input  logic          FillIncr,
    output logic          Busy,
    output logic          Done,
    output logic [DW-1:0] RdData,
    output logic          RdValid,
    input  logic          RdReady,
    output logic          MemWrite,
    output logic [AW-1:0] MemAddress,
    output logic [DW-1:0] MemDataIn,
    input  logic [DW-1:0] MemDataOut
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAP   = 3'd3,
        RD_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          incr_q, incr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;

    // The memory-facing address and data registers double as the transfer
    // cursor, so the memory always sees exactly the value being walked.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        incr_d      = incr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    incr_d     = FillIncr;
                    busy_d     = 1'b1;
                    mem_addr_d = BaseAddr;
                    if (Length == '0) begin
                        state_d = DONE;
                    end else if (!Op) begin
                        state_d     = FILL;
                        mem_write_d = 1'b1;
                        mem_din_d   = FillData;
                        count_d     = Length - (AW+1)'(1);
                    end else begin
                        state_d = RD_ISSUE;
                        count_d = Length;
                    end
                end
            end

            // count_q holds the writes still owed after the one on the bus now.
            FILL: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = mem_addr_q + AW'(1);
                    mem_din_d   = mem_din_q + DW'(incr_q);
                    count_d     = count_q - (AW+1)'(1);
                end
            end

            // Address is already on the bus; this cycle lets a registered-read
            // memory produce data before RD_CAP samples it.
            RD_ISSUE: begin
                state_d = RD_CAP;
            end

            RD_CAP: begin
                rd_data_d  = MemDataOut;
                rd_valid_d = 1'b1;
                state_d    = RD_HOLD;
            end

            RD_HOLD: begin
                if (rd_valid_q && RdReady) begin
                    rd_valid_d = 1'b0;
                    mem_addr_d = mem_addr_q + AW'(1);
                    count_d    = count_q - (AW+1)'(1);
                    state_d    = (count_q == (AW+1)'(1)) ? DONE : RD_ISSUE;
                end
            end

            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            incr_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            incr_q      <= incr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign RdData     = rd_data_q;
    assign RdValid    = rd_valid_q;
    assign MemWrite   = mem_write_q;
    assign MemAddress = mem_addr_q;
    assign MemDataIn  = mem_din_q;

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Scoreboard bench for mem_block_ctrl with a registered-read 1k x 16 memory model.
module tb_mem_block_ctrl;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Op = 1'b0;
    logic [AW-1:0] BaseAddr = '0;
    logic [AW:0]   Length = '0;
    logic [DW-1:0] FillData = '0;
    logic          FillIncr = 1'b0;
    logic          Busy, Done, RdValid, MemWrite;
    logic [DW-1:0] RdData, MemDataIn, MemDataOut;
    logic          RdReady = 1'b0;
    logic [AW-1:0] MemAddress;

    mem_block_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .BaseAddr(BaseAddr),
        .Length(Length), .FillData(FillData), .FillIncr(FillIncr), .Busy(Busy),
        .Done(Done), .RdData(RdData), .RdValid(RdValid), .RdReady(RdReady),
        .MemWrite(MemWrite), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
        .MemDataOut(MemDataOut)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] mem_rd = '0;
    always @(posedge CLK) begin
        if (MemWrite) mem[MemAddress] <= MemDataIn;
        mem_rd <= mem[MemAddress];
    end
    assign MemDataOut = mem_rd;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    int done_count = 0;
    logic [AW+DW-1:0] exp_wr[$];
    logic [DW-1:0]    exp_rd[$];

    // Monitor: every write and every read handshake is checked against the queues.
    always @(negedge CLK) begin
        logic [AW+DW-1:0] ew;
        logic [DW-1:0]    er;
        if (!Reset) begin
            if (MemWrite) begin
                wr_count++;
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write addr=%0d data=%h", MemAddress, MemDataIn);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({MemAddress, MemDataIn} !== ew) begin
                        miscompares++;
                        $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                                 MemAddress, MemDataIn, ew[AW+DW-1:DW], ew[DW-1:0]);
                    end
                end
            end
            if (RdValid && RdReady) begin
                vectors++;
                if (exp_rd.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_read data=%h", RdData);
                end else begin
                    er = exp_rd.pop_front();
                    if (RdData !== er) begin
                        miscompares++;
                        $display("FAIL read_data got=%h want=%h", RdData, er);
                    end
                end
            end
            if (Done) done_count++;
        end
    end

    task automatic start_cmd(input logic op, input int base, input int len,
                             input int data, input logic incr);
        @(posedge CLK); #1;
        Op = op; BaseAddr = AW'(base); Length = (AW+1)'(len);
        FillData = DW'(data); FillIncr = incr; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge CLK); #1;
            cyc++;
            if (Done) ok = 1'b1;
        end
    endtask

    task automatic push_fill(input int base, input int len, input int data, input logic incr);
        for (int i = 0; i < len; i++)
            exp_wr.push_back({AW'(base + i), DW'(data + (incr ? i : 0))});
    endtask

    task automatic test_reset();
        int d0;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({Busy, Done, RdValid, MemWrite, MemAddress, RdData, MemDataIn} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b done=%b rdv=%b mw=%b addr=%0d rdd=%h din=%h want all 0",
                     Busy, Done, RdValid, MemWrite, MemAddress, RdData, MemDataIn);
        end
        Reset = 1'b0;
        push_fill(100, 8, 16'h0055, 1'b0);
        start_cmd(1'b0, 100, 8, 16'h0055, 1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        Reset = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if ({MemWrite, Busy, Done, RdValid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_fill got mw=%b busy=%b done=%b rdv=%b want 0000",
                     MemWrite, Busy, Done, RdValid);
        end
        @(posedge CLK); #1;
        Reset = 1'b0;
        exp_wr.delete();
        d0 = done_count;
        repeat (4) begin @(posedge CLK); #1; end
        vectors++;
        if (done_count != d0 || Busy !== 1'b0 || MemWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done got done_pulses=%0d busy=%b mw=%b want 0 0 0",
                     done_count - d0, Busy, MemWrite);
        end
        vectors++;
        if (mem[100] !== 16'h0055) begin
            miscompares++;
            $display("FAIL reset_mem_kept got=%h want=0055", mem[100]);
        end
        $display("test_reset done");
    endtask

    task automatic test_fill_incr();
        int w0, cyc;
        bit ok;
        w0 = wr_count;
        push_fill(1, 4, 16'h00A0, 1'b1);
        start_cmd(1'b0, 1, 4, 16'h00A0, 1'b1);
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_busy got=%b want=1", Busy);
        end
        wait_done(20, cyc, ok);
        vectors++;
        if (!ok || cyc != 5 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_done got ok=%0d cycles=%0d busy=%b want ok=1 cycles=5 busy=0", ok, cyc, Busy);
        end
        vectors++;
        if (wr_count - w0 != 4 || exp_wr.size() != 0) begin
            miscompares++;
            $display("FAIL fill_count got writes=%0d left=%0d want 4 0", wr_count - w0, exp_wr.size());
        end
        w0 = wr_count;
        RdReady = 1'b1;
        for (int i = 0; i < 4; i++) exp_rd.push_back(DW'(16'h00A0 + i));
        start_cmd(1'b1, 1, 4, 0, 1'b0);
        wait_done(40, cyc, ok);
        vectors++;
        if (!ok || cyc != 13 || exp_rd.size() != 0 || wr_count != w0) begin
            miscompares++;
            $display("FAIL readback got ok=%0d cycles=%0d left=%0d writes=%0d want 1 13 0 0",
                     ok, cyc, exp_rd.size(), wr_count - w0);
        end
        $display("test_fill_incr done");
    endtask

    task automatic test_read_backpressure();
        int w0, cyc;
        bit ok, seen;
        push_fill(2, 1, 16'h1234, 1'b0);
        start_cmd(1'b0, 2, 1, 16'h1234, 1'b0);
        wait_done(10, cyc, ok);
        push_fill(3, 1, 16'h5678, 1'b0);
        start_cmd(1'b0, 3, 1, 16'h5678, 1'b0);
        wait_done(10, cyc, ok);
        vectors++;
        if (!ok || cyc != 2) begin
            miscompares++;
            $display("FAIL preload_len1 got ok=%0d cycles=%0d want 1 2", ok, cyc);
        end
        RdReady = 1'b0;
        w0 = wr_count;
        exp_rd.push_back(16'h1234);
        exp_rd.push_back(16'h5678);
        start_cmd(1'b1, 2, 2, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge CLK); #1;
            if (RdValid) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL bp_valid_timeout got rdvalid=0 want 1");
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            vectors++;
            if (RdValid !== 1'b1 || RdData !== 16'h1234) begin
                miscompares++;
                $display("FAIL bp_hold cycle=%0d got rdv=%b data=%h want 1 1234", i, RdValid, RdData);
            end
        end
        RdReady = 1'b1;
        wait_done(20, cyc, ok);
        vectors++;
        if (!ok || exp_rd.size() != 0 || wr_count != w0) begin
            miscompares++;
            $display("FAIL bp_finish got ok=%0d left=%0d writes=%0d want 1 0 0", ok, exp_rd.size(), wr_count - w0);
        end
        $display("test_read_backpressure done");
    endtask

    task automatic test_wrap();
        int cyc;
        bit ok;
        exp_wr.push_back({10'd1022, 16'hFFFF});
        exp_wr.push_back({10'd1023, 16'h0000});
        exp_wr.push_back({10'd0,    16'h0001});
        exp_wr.push_back({10'd1,    16'h0002});
        start_cmd(1'b0, 1022, 4, 16'hFFFF, 1'b1);
        wait_done(20, cyc, ok);
        vectors++;
        if (!ok || cyc != 5 || exp_wr.size() != 0) begin
            miscompares++;
            $display("FAIL wrap got ok=%0d cycles=%0d left=%0d want 1 5 0", ok, cyc, exp_wr.size());
        end
        vectors++;
        if (mem[0] !== 16'h0001 || mem[1023] !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_mem got m0=%h m1023=%h want 0001 0000", mem[0], mem[1023]);
        end
        $display("test_wrap done");
    endtask

    task automatic test_zero_len_busy();
        int w0, cyc;
        bit ok;
        w0 = wr_count;
        start_cmd(1'b0, 5, 0, 16'hBEEF, 1'b0);
        vectors++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_busy got busy=%b done=%b want 1 0", Busy, Done);
        end
        @(posedge CLK); #1;
        vectors++;
        if (Done !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_done got done=%b busy=%b want 1 0", Done, Busy);
        end
        @(posedge CLK); #1;
        vectors++;
        if (Done !== 1'b0 || wr_count != w0) begin
            miscompares++;
            $display("FAIL zero_len_after got done=%b writes=%0d want 0 0", Done, wr_count - w0);
        end
        push_fill(200, 8, 16'h0300, 1'b1);
        start_cmd(1'b0, 200, 8, 16'h0300, 1'b1);
        repeat (2) begin @(posedge CLK); #1; end
        Start = 1'b1; BaseAddr = 10'd500; Length = 11'd3; FillData = 16'hDEAD;
        @(posedge CLK); #1;
        Start = 1'b0;
        wait_done(20, cyc, ok);
        repeat (5) begin @(posedge CLK); #1; end
        vectors++;
        if (!ok || wr_count - w0 != 8 || exp_wr.size() != 0) begin
            miscompares++;
            $display("FAIL busy_start got ok=%0d writes=%0d left=%0d want 1 8 0", ok, wr_count - w0, exp_wr.size());
        end
        $display("test_zero_len_busy done");
    endtask

    task automatic test_full_sweep();
        int cyc, bad;
        bit ok;
        push_fill(0, 1024, 0, 1'b1);
        start_cmd(1'b0, 0, 1024, 0, 1'b1);
        wait_done(1100, cyc, ok);
        vectors++;
        if (!ok || cyc != 1025 || exp_wr.size() != 0) begin
            miscompares++;
            $display("FAIL sweep_fill got ok=%0d cycles=%0d left=%0d want 1 1025 0", ok, cyc, exp_wr.size());
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== DW'(i)) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL sweep_mem got bad_words=%0d want 0", bad);
        end
        RdReady = 1'b1;
        for (int i = 0; i < 1024; i++) exp_rd.push_back(DW'(i));
        start_cmd(1'b1, 0, 1024, 0, 1'b0);
        wait_done(3200, cyc, ok);
        vectors++;
        if (!ok || cyc != 3073 || exp_rd.size() != 0) begin
            miscompares++;
            $display("FAIL sweep_read got ok=%0d cycles=%0d left=%0d want 1 3073 0", ok, cyc, exp_rd.size());
        end
        $display("test_full_sweep done");
    endtask

    initial begin
        test_reset();
        test_fill_incr();
        test_read_backpressure();
        test_wrap();
        test_zero_len_busy();
        test_full_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
